// File: rtl/ram_sync_init.sv
// Synchronous single-port RAM with active-low host strobes and a built-in
// clear engine that fills every word with FILL and optionally reads it back.
module ram_sync_init #(
  parameter int                ADDR_W    = 7,
  parameter int                DATA_W    = 16,
  parameter logic [DATA_W-1:0] FILL      = '0,
  parameter bit                VERIFY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] adrs,
  input  logic [DATA_W-1:0] din,
  input  logic              _ce,
  input  logic              _we,
  input  logic              _oe,
  input  logic              clr_req,
  output logic [DATA_W-1:0] dout,
  output logic              rd_vld,
  output logic              host_rej,
  output logic              busy,
  output logic              init_done,
  output logic              err
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, CLEAR, VERIFY} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   ptr, ptr_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                service, host_wr, host_rd, drop, last;
  logic                mem_we, eng_rd, mismatch;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;

  // Engine read-back stage: data and its valid, one cycle behind the read
  logic [DATA_W-1:0]   vfy_data_p1;
  logic                vld_p1;
  logic                tail_p1;

  assign service  = (state == IDLE) && !clr_req;
  assign host_wr  = service && !_ce && !_we;
  assign host_rd  = service && !_ce && _we && !_oe;
  assign drop     = !_ce && !service;
  assign last     = (ptr == ADDR_W'(DEPTH - 1));
  assign busy     = (state != IDLE);
  assign mismatch = (state == VERIFY) && vld_p1 && (vfy_data_p1 != FILL);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_addr  = adrs;
    mem_wdata = din;
    eng_rd    = 1'b0;
    case (state)
      IDLE: begin
        mem_we = host_wr;
        if (clr_req) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = ptr;
        mem_wdata = FILL;
        ptr_nxt   = ptr + 1'b1;
        // Terminal test on the pointer value itself, not on wrap-around
        if (last) begin
          ptr_nxt   = '0;
          state_nxt = VERIFY_EN ? VERIFY : IDLE;
        end
      end
      VERIFY: begin
        mem_addr = ptr;
        if (!tail_p1) begin
          eng_rd  = 1'b1;
          ptr_nxt = ptr + 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Array storage and engine read port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (eng_rd) vfy_data_p1 <= mem[mem_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      vld_p1    <= 1'b0;
      tail_p1   <= 1'b0;
      dout      <= '0;
      rd_vld    <= 1'b0;
      host_rej  <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      vld_p1    <= eng_rd;
      rd_vld    <= host_rd;
      host_rej  <= drop;
      init_done <= (state != IDLE) && (state_nxt == IDLE);
      if (state != VERIFY)
        tail_p1 <= 1'b0;
      else if (eng_rd && last)
        tail_p1 <= 1'b1;
      if (state == IDLE && clr_req)
        err <= 1'b0;
      else if (mismatch)
        err <= 1'b1;
      if (host_rd)
        dout <= mem[mem_addr];
    end
  end

endmodule

// File: tb/tb_ram_sync_init.sv
// Scoreboard bench for ram_sync_init: clear/verify sequencing, host access,
// dropped accesses, verify error injection and reset abort.
module tb_ram_sync_init;

  localparam int          ADDR_W = 7;
  localparam int          DATA_W = 16;
  localparam int          DEPTH  = 2 ** ADDR_W;
  localparam logic [15:0] FILL   = 16'h0000;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] adrs = '0;
  logic [DATA_W-1:0] din = '0;
  logic              cen = 1'b1;
  logic              wen = 1'b1;
  logic              oen = 1'b1;
  logic              clr_req = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              rd_vld, host_rej, busy, init_done, err;

  int n_checks = 0;
  int n_errors = 0;
  int run = 0;
  int last_run = 0;

  logic [DATA_W-1:0] exp_mem [DEPTH];
  logic [DATA_W-1:0] sb [$];

  ram_sync_init #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FILL(FILL), .VERIFY_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .adrs(adrs), .din(din),
    ._ce(cen), ._we(wen), ._oe(oen), .clr_req(clr_req),
    .dout(dout), .rd_vld(rd_vld), .host_rej(host_rej),
    .busy(busy), .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic c, input logic w, input logic o,
                    input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    cen = c; wen = w; oen = o; adrs = a; din = d;
  endtask

  task automatic idle_bus();
    op(1'b1, 1'b1, 1'b1, '0, '0);
  endtask

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    op(1'b0, 1'b0, 1'b1, a, d);
    exp_mem[a] = d;
  endtask

  task automatic host_read(input logic [ADDR_W-1:0] a);
    op(1'b0, 1'b1, 1'b0, a, '0);
    sb.push_back(exp_mem[a]);
  endtask

  task automatic fill_model();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = FILL;
  endtask

  // Pulse clr_req for one edge; returns just after that edge
  task automatic start_clr();
    @(negedge clk);
    clr_req = 1'b1;
    @(posedge clk);
    #1;
    clr_req = 1'b0;
    check("clr_busy", busy, 1);
    check("clr_err_cleared", err, 0);
  endtask

  // Count edges until busy falls; 'done' edges of the window already elapsed
  task automatic wait_init(input string tag, input int done);
    int cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (busy && cnt < 2000);
    check({tag, "_busy_len"}, cnt, 257 - done);
    check({tag, "_init_done"}, init_done, 1);
    @(posedge clk);
    #1;
    check({tag, "_init_pulse"}, init_done, 0);
    check({tag, "_busy_low"}, busy, 0);
    fill_model();
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  // Output monitor: every rd_vld pops one expected word
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        run = 0;
      end else if (rd_vld) begin
        run++;
        if (sb.size() == 0) check("rd_vld_unexpected", rd_vld, 0);
        else check("dout", dout, sb.pop_front());
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fill_model();
    // Test 1: reset then full clear + verify window
    #2 rst = 1'b1;
    @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_rd_vld", rd_vld, 0);
    check("rst_host_rej", host_rej, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 1);
    @(negedge clk);
    rst = 1'b0;
    wait_init("t1", 0);
    check("t1_err", err, 0);

    // Test 2: write adrs*3 everywhere, back-to-back readback
    for (int a = 0; a < DEPTH; a++) host_write(ADDR_W'(a), DATA_W'(a * 3));
    for (int a = 0; a < DEPTH; a++) host_read(ADDR_W'(a));
    idle_bus();
    drain("t2");
    check("t2_rd_vld_run", last_run, DEPTH);

    // Test 3: combined write+read strobe writes only; readback next cycle
    op(1'b0, 1'b0, 1'b0, 7'd5, 16'hBEEF);
    exp_mem[5] = 16'hBEEF;
    host_read(7'd5);
    idle_bus();
    drain("t3");
    check("t3_run", last_run, 1);

    // Test 4: write while busy is dropped and flagged
    start_clr();
    op(1'b0, 1'b0, 1'b1, 7'd9, 16'h1234);
    @(posedge clk);
    #1;
    check("t4_host_rej", host_rej, 1);
    idle_bus();
    @(posedge clk);
    #1;
    check("t4_host_rej_pulse", host_rej, 0);
    wait_init("t4", 2);
    host_read(7'd9);
    host_read(7'd10);
    idle_bus();
    drain("t4");

    // Test 5: corrupt a word mid-VERIFY, err must stick until next clr_req
    start_clr();
    repeat (143) @(posedge clk);
    @(negedge clk);
    dut.mem[40] = 16'h00FF;
    wait_init("t5a", 143);
    exp_mem[40] = 16'h00FF;
    check("t5_err_set", err, 1);
    host_read(7'd40);
    idle_bus();
    drain("t5");
    check("t5_err_sticky", err, 1);
    start_clr();
    wait_init("t5b", 0);
    check("t5_err_rerun", err, 0);

    // Test 6: reset during CLEAR at ptr 60 restarts the whole sequence
    start_clr();
    repeat (60) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 1);
    check("t6_rst_init_done", init_done, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_init("t6", 0);
    check("t6_err", err, 0);
    host_read(7'd5);
    host_read(7'd127);
    idle_bus();
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
